// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes 32-bit host transfers into a 32-entry register bank
// shared with periodic encoder snapshots. Optional feature macro: CMD_PARITY_EN.
module spi_reg_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ERR_WORD    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic [31:0] spi_q,
    output logic [31:0] spi_d,
    input  logic        enc_valid,
    input  logic [15:0] enc_left,
    input  logic [15:0] enc_right,
    output logic        cfg_we,
    output logic [4:0]  cfg_adr,
    output logic [11:0] cfg_wd
);

    typedef enum logic [1:0] {IDLE, DECODE, RD_WAIT, RESP} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_d;
    logic                   cmd_stb;

    logic [31:0] cmd;
    logic [4:0]  rd_adr;
    logic [31:0] resp, resp_n;
    logic        skip_cnt, skip_cnt_n;
    logic [31:0] bank [0:31];
    logic        enc_ovr, busy_err, par_err;
    logic [15:0] cmd_count;
    logic        pend;
    logic [31:0] pend_data;

    logic        host_we, clr_sticky, par_set, drain;
    logic        parity_ok;
    logic        re;
    logic [4:0]  adr;
    logic [11:0] wd;
    logic [31:0] echo, status;

    // Sync flops reset high so an idle (high) CS after reset is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync <= '1;
            cs_d    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            cs_d    <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign cmd_stb = cs_sync[SYNC_STAGES-1] & ~cs_d;

    assign re     = cmd[31];
    assign adr    = cmd[30:26];
    assign wd     = cmd[25:14];
    assign echo   = {1'b0, adr, wd, 14'b0};
    assign status = {enc_ovr, busy_err, par_err, 13'b0, cmd_count};

`ifdef CMD_PARITY_EN
    assign parity_ok = ~^cmd;
`else
    assign parity_ok = 1'b1;
    logic unused_cmd_bits;
    assign unused_cmd_bits = &{1'b0, cmd[13:0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        resp_n     = resp;
        skip_cnt_n = skip_cnt;
        host_we    = 1'b0;
        clr_sticky = 1'b0;
        par_set    = 1'b0;
        case (state)
            IDLE: if (cmd_stb) state_n = DECODE;
            DECODE: begin
                skip_cnt_n = 1'b0;
                if (!parity_ok) begin
                    resp_n     = ERR_WORD;
                    par_set    = 1'b1;
                    skip_cnt_n = 1'b1;
                    state_n    = RESP;
                end else if (re) begin
                    state_n = RD_WAIT;
                end else begin
                    resp_n  = echo;
                    state_n = RESP;
                    if (adr == 5'd31)      clr_sticky = 1'b1;
                    else if (adr != 5'd0)  host_we    = 1'b1;
                end
            end
            RD_WAIT: begin
                resp_n  = (rd_adr == 5'd31) ? status : bank[rd_adr];
                state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Snapshot may use the bank port whenever the host is not writing it.
    assign drain = pend && (state != DECODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd       <= '0;
            rd_adr    <= '0;
            resp      <= '0;
            skip_cnt  <= 1'b0;
            spi_d     <= '0;
            cmd_count <= '0;
            cfg_we    <= 1'b0;
            cfg_adr   <= '0;
            cfg_wd    <= '0;
        end else begin
            resp     <= resp_n;
            skip_cnt <= skip_cnt_n;
            cfg_we   <= host_we;
            if (state == IDLE && cmd_stb) cmd <= spi_q;
            if (state == DECODE)          rd_adr <= adr;
            if (host_we) begin
                cfg_adr <= adr;
                cfg_wd  <= wd;
            end
            if (state == RESP) begin
                spi_d <= resp;
                if (!skip_cnt) cmd_count <= cmd_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
        end else begin
            if (host_we) bank[adr] <= {20'b0, wd};
            if (drain)   bank[0]   <= pend_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else if (enc_valid) begin
            pend      <= 1'b1;
            pend_data <= {enc_left, enc_right};
        end else if (drain) begin
            pend <= 1'b0;
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_ovr  <= 1'b0;
            busy_err <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            enc_ovr  <= (enc_valid && pend && !drain) | (enc_ovr  & ~clr_sticky);
            busy_err <= (cmd_stb && state != IDLE)    | (busy_err & ~clr_sticky);
            par_err  <= par_set                       | (par_err  & ~clr_sticky);
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected responses and cfg writes are queued at
// stimulus time and popped when the transfer completes / cfg_we fires.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic [31:0] spi_q;
    logic [31:0] spi_d;
    logic        enc_valid;
    logic [15:0] enc_left, enc_right;
    logic        cfg_we;
    logic [4:0]  cfg_adr;
    logic [11:0] cfg_wd;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [16:0] cfg_q [$];
    logic [15:0] cnt;
    logic        ovr, bsy, par;

    spi_reg_ctrl dut (
        .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_q(spi_q), .spi_d(spi_d),
        .enc_valid(enc_valid), .enc_left(enc_left), .enc_right(enc_right),
        .cfg_we(cfg_we), .cfg_adr(cfg_adr), .cfg_wd(cfg_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic r, input logic [4:0] a, input logic [11:0] d);
        mk = {r, a, d, 14'b0};
    endfunction

    function automatic logic [31:0] fix(input logic [31:0] w);
`ifdef CMD_PARITY_EN
        fix = {w[31:1], ^w[31:1]};
`else
        fix = w;
`endif
    endfunction

    function automatic logic [31:0] status_w();
        status_w = {ovr, bsy, par, 13'b0, cnt};
    endfunction

    always @(negedge clk) begin
        if (cfg_we) begin
            if (cfg_q.size() == 0) check("cfg_we_unexpected", 32'(cfg_we), 32'd0);
            else check("cfg_write", {15'b0, cfg_adr, cfg_wd}, {15'b0, cfg_q.pop_front()});
        end
    end

    task automatic cs_pulse(input logic [31:0] w);
        @(negedge clk);
        spi_q  = w;
        spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        spi_cs = 1'b1;
    endtask

    task automatic finish_xfer(input string tag);
        repeat (12) @(negedge clk);
        if (exp_q.size() == 0) check({tag, "_noexp"}, 32'd0, 32'd1);
        else check(tag, spi_d, exp_q.pop_front());
    endtask

    task automatic wr(input logic [4:0] a, input logic [11:0] d);
        exp_q.push_back(mk(1'b0, a, d));
        if (a != 5'd0 && a != 5'd31) cfg_q.push_back({a, d});
        cs_pulse(fix(mk(1'b0, a, d)));
        finish_xfer("write_resp");
        if (a == 5'd31) {ovr, bsy, par} = 3'b000;
        cnt++;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        cs_pulse(fix(mk(1'b1, a, 12'h000)));
        finish_xfer("read_resp");
        cnt++;
    endtask

    initial begin
        reset = 1'b1; spi_cs = 1'b1; spi_q = '0;
        enc_valid = 1'b0; enc_left = '0; enc_right = '0;
        cnt = '0; {ovr, bsy, par} = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_spi_d", spi_d, 32'd0);
        check("rst_cfg", {19'b0, cfg_we, cfg_adr, cfg_wd}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // reset while the first command sits in DECODE: it must vanish
        cs_pulse(fix(mk(1'b0, 5'd3, 12'h555)));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_spi_d", spi_d, 32'd0);
        check("midrst_cfg_we", 32'(cfg_we), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rd(5'd31, status_w());
        rd(5'd3, 32'd0);

        // host write / readback, including the top config address and full data
        wr(5'd3, 12'hABC);
        rd(5'd3, 32'h0000_0ABC);
        wr(5'd30, 12'hFFF);
        rd(5'd30, 32'h0000_0FFF);
        rd(5'd1, 32'd0);
        wr(5'd0, 12'h123);
        rd(5'd0, 32'd0);

        // single encoder snapshot
        @(negedge clk);
        enc_left = 16'h8005; enc_right = 16'h7FFE; enc_valid = 1'b1;
        @(negedge clk);
        enc_valid = 1'b0;
        repeat (3) @(negedge clk);
        rd(5'd0, 32'h8005_7FFE);

        // back-to-back samples while the FSM is in DECODE -> overrun, newest kept
        exp_q.push_back(mk(1'b0, 5'd2, 12'h055));
        cfg_q.push_back({5'd2, 12'h055});
        cs_pulse(fix(mk(1'b0, 5'd2, 12'h055)));
        @(negedge clk);
        @(negedge clk);
        enc_valid = 1'b1; enc_left = 16'h1111; enc_right = 16'h2222;
        @(negedge clk);
        enc_left = 16'h3333; enc_right = 16'h4444;
        @(negedge clk);
        enc_valid = 1'b0;
        finish_xfer("ovr_write_resp");
        cnt++;
        ovr = 1'b1;
        rd(5'd0, 32'h3333_4444);
        rd(5'd31, status_w());
        wr(5'd31, 12'h000);
        rd(5'd31, status_w());

        // second strobe two clocks after the first is dropped
        exp_q.push_back(mk(1'b0, 5'd5, 12'h123));
        cfg_q.push_back({5'd5, 12'h123});
        cs_pulse(fix(mk(1'b0, 5'd5, 12'h123)));
        @(negedge clk);
        spi_cs = 1'b0;
        @(negedge clk);
        spi_cs = 1'b1;
        finish_xfer("busy_first_resp");
        cnt++;
        bsy = 1'b1;
        rd(5'd31, status_w());
        rd(5'd5, 32'h0000_0123);

`ifdef CMD_PARITY_EN
        exp_q.push_back(32'hFFFF_FFFF);
        cs_pulse(32'h0EAF_0000);
        finish_xfer("par_reject_resp");
        par = 1'b1;
        rd(5'd31, status_w());
        exp_q.push_back(32'h0EAF_0000);
        cfg_q.push_back({5'd3, 12'hABC});
        cs_pulse(32'h0EAF_0001);
        finish_xfer("par_accept_resp");
        cnt++;
`endif

        repeat (4) @(negedge clk);
        check("cfg_pending", cfg_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
